modmul_seq: RTL and testbench

MODMUL_SEQ -- requirements
Module: modmul_seq

---
 rtl/modmul_pkg.sv | 23 ++
 rtl/modmul_step.sv | 44 ++++
 rtl/modmul_seq.sv | 137 +++++++++++++
 tb/tb_modmul_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modmul_pkg
// Description : Shared definitions for the sequential modular multiplier:
//               FSM state encoding and the iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package modmul_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that indexes DATA_WIDTH iterations (0..DATA_WIDTH-1).
  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage : modmul_pkg
`default_nettype wire

// File: rtl/modmul_step.sv
`default_nettype none
// ============================================================================
// Module      : modmul_step
// Description : One combinational shift-add-reduce iteration of an MSB-first
//               interleaved modular multiplication:
//                 t = 2*r + (bit ? a : 0);  then subtract m up to twice.
// Ports       : r_in   - current accumulator (DATA_WIDTH+2 bits, r_in < m)
//               a_in   - multiplicand (a_in < m)
//               bit_in - current multiplier bit
//               m_in   - modulus
//               r_out  - reduced accumulator (< m)
// Revision    : 1.0 - initial release
// ============================================================================
module modmul_step #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH+1:0] r_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  bit_in,
  input  logic [DATA_WIDTH-1:0] m_in,
  output logic [DATA_WIDTH+1:0] r_out
);

  localparam int RW = DATA_WIDTH + 2;

  logic [RW-1:0] w_m;
  logic [RW-1:0] w_dbl;
  logic [RW-1:0] w_sum;
  logic [RW-1:0] w_sub1;
  logic [RW-1:0] w_sub2;

  // With r < m and a < m, 2r + a < 3m, so two conditional subtracts always
  // bring the result back below m. Two guard bits keep 2r + a from wrapping.
  always_comb begin
    w_m    = {2'b00, m_in};
    w_dbl  = r_in << 1;
    w_sum  = w_dbl + (bit_in ? {2'b00, a_in} : {RW{1'b0}});
    w_sub1 = (w_sum  >= w_m) ? (w_sum  - w_m) : w_sum;
    w_sub2 = (w_sub1 >= w_m) ? (w_sub1 - w_m) : w_sub1;
    r_out  = w_sub2;
  end

endmodule : modmul_step
`default_nettype wire

// File: rtl/modmul_seq.sv
`default_nettype none
// ============================================================================
// Module      : modmul_seq
// Description : Sequential modular multiplier computing (a*b) mod modulant,
//               one bit of b per cycle MSB-first, with valid/ready handshakes.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               in_valid / in_ready   - operand handshake (ready only in IDLE)
//               a, b, modulant        - operands, captured on accept
//               out_valid / out_ready - result handshake (valid only in DONE)
//               out                   - (a*b) mod modulant
//               err                   - modulant==0 or a>=modulant
// Revision    : 1.0 - initial release
// ============================================================================
module modmul_seq
  import modmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] modulant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  err
);

  localparam int RW = DATA_WIDTH + 2;
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] C_LAST_CNT = CW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [RW-1:0]         r_q,     r_d;
  logic [DATA_WIDTH-1:0] a_q,     a_d;
  logic [DATA_WIDTH-1:0] b_q,     b_d;
  logic [DATA_WIDTH-1:0] m_q,     m_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic                  err_q,   err_d;

  logic [RW-1:0]         w_r_next;
  logic                  w_accept;
  logic                  w_bad_ops;

  // b is shifted left each iteration, so its MSB is always the current bit.
  modmul_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .r_in   (r_q),
    .a_in   (a_q),
    .bit_in (b_q[DATA_WIDTH-1]),
    .m_in   (m_q),
    .r_out  (w_r_next)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = r_q[DATA_WIDTH-1:0];
  assign err       = err_q;

  assign w_accept  = in_valid && in_ready;
  assign w_bad_ops = (modulant == '0) || (a >= modulant);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          a_d   = a;
          b_d   = b;
          m_d   = modulant;
          r_d   = '0;
          cnt_d = '0;
          if (w_bad_ops) begin
            // Rejected operation: report immediately with a zero result.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        r_d   = w_r_next;
        b_d   = {b_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_CNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule : modmul_seq
`default_nettype wire

// File: tb/tb_modmul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_modmul_seq
// Description : Directed self-checking bench for modmul_seq (DATA_WIDTH=8)
//               followed by a randomized run against a (a*b)%m reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modmul_seq;

  localparam int DW      = 8;
  localparam int N_RAND  = 2000;
  localparam int TIMEOUT = 50;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] modulant;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;
  logic          err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  modmul_seq #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .modulant  (modulant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one operand set, wait for acceptance, then scramble the inputs
  // so that any failure to capture them shows up in the result.
  task automatic issue(input logic [DW-1:0] ia, input logic [DW-1:0] ib, input logic [DW-1:0] im);
    int n;
    n = 0;
    while (!in_ready && n < TIMEOUT) begin
      tick();
      n++;
    end
    if (!in_ready) check("issue_ready_timeout", 32'(in_ready), 32'd1);
    a        = ia;
    b        = ib;
    modulant = im;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = DW'($urandom);
    b        = DW'($urandom);
    modulant = DW'($urandom);
  endtask

  // Edges after the accept edge until out_valid is seen (0 = rose on accept edge).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                        input logic [DW-1:0] im, input int exp_lat,
                        input logic [DW-1:0] exp_out, input logic exp_err);
    int lat;
    issue(ia, ib, im);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    pop();
  endtask

  initial begin
    int lat;
    int c0;
    int c1;
    int n;
    logic seen;
    logic [DW-1:0] ra, rb, rm;
    logic [15:0]   prod;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    modulant  = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out",       32'(out),       32'd0);
    check("rst_err",       32'(err),       32'd0);

    // Main function: 63 mod 13 = 11 ; 51000 mod 251 = 47
    run_op("basic",   8'd7,   8'd9,   8'd13,  8,  8'd11, 1'b0);
    run_op("large",   8'd200, 8'd255, 8'd251, 8,  8'd47, 1'b0);
    // 12*12 = 144 = 11*13 + 1 ; 254*255 is a multiple of 255
    run_op("a_max",   8'd12,  8'd12,  8'd13,  8,  8'd1,  1'b0);
    run_op("m_255",   8'd254, 8'd255, 8'd255, 8,  8'd0,  1'b0);

    // Rejected operations: result presented right after the accept edge
    run_op("m_zero",  8'd5,   8'd9,   8'd0,   0,  8'd0,  1'b1);
    run_op("a_gt_m",  8'd20,  8'd3,   8'd13,  0,  8'd0,  1'b1);
    run_op("a_eq_m",  8'd13,  8'd1,   8'd13,  0,  8'd0,  1'b1);

    // Degenerate but legal operations
    run_op("m_one",   8'd0,   8'd200, 8'd1,   8,  8'd0,  1'b0);
    run_op("b_zero",  8'd12,  8'd0,   8'd13,  8,  8'd0,  1'b0);

    // Back-pressure: result held, new operands ignored while in DONE
    issue(8'd7, 8'd9, 8'd13);
    out_ready = 1'b1;   // must be ignored while the operation runs
    tick();
    out_ready = 1'b0;
    wait_done(lat);
    check("stall_lat", 32'(lat), 32'd7);
    a        = 8'd3;
    b        = 8'd5;
    modulant = 8'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_out",      32'(out),       32'd11);
      check("stall_in_ready", 32'(in_ready),  32'd0);
      tick();
    end
    in_valid = 1'b0;
    pop();
    check("stall_idle_ready", 32'(in_ready),  32'd1);
    check("stall_idle_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of RUN aborts silently
    issue(8'd7, 8'd9, 8'd13);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_valid", 32'(seen),     32'd0);
    check("abort_ready",    32'(in_ready), 32'd1);
    run_op("after_abort", 8'd3, 8'd5, 8'd7, 8, 8'd1, 1'b0);

    // Throughput with both handshakes held high: one op per DW+2 cycles
    a         = 8'd7;
    b         = 8'd9;
    modulant  = 8'd13;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();             // accept edge
    c0 = cyc;
    n  = 0;
    while (!in_ready && n < TIMEOUT) begin
      tick();
      n++;
    end
    tick();             // second accept edge
    c1 = cyc;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("throughput", 32'(c1 - c0), 32'(DW + 2));
    wait_done(lat);
    check("throughput_out", 32'(out), 32'd11);
    pop();

    // Randomized operations with random consumer back-pressure
    for (int k = 0; k < N_RAND; k++) begin
      rm   = DW'($urandom_range(1, 255));
      ra   = DW'($urandom_range(0, 32'(rm) - 1));
      rb   = DW'($urandom_range(0, 255));
      prod = 16'(ra) * 16'(rb);
      issue(ra, rb, rm);
      wait_done(lat);
      check("rand_out", 32'(out), 32'(prod % 16'(rm)));
      n = 0;
      out_ready = DW'($urandom_range(0, 1)) != 0;
      while (!(out_ready && out_valid) && n < TIMEOUT) begin
        tick();
        n++;
        out_ready = $urandom_range(0, 1) != 0;
      end
      tick();
      out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_modmul_seq
`default_nettype wire
